lutram_fifo: RTL and testbench



---
 rtl/lutram_fifo_if.sv | 32 +++
 rtl/lutram_fifo.sv | 122 ++++++++++++
 tb/tb_lutram_fifo.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lutram_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lutram_fifo_if                                                             |
// | Push/pop handshake and status bundle for the 64-entry distributed-RAM FIFO |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface lutram_fifo_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] wrdata;
  logic             wren;
  logic             full;
  logic             almost_full;
  logic [WIDTH-1:0] rddata;
  logic             rden;
  logic             empty;
  logic [6:0]       count;
  logic             overflow;
  logic             underflow;

  // The master is the producer/consumer pair driving the FIFO.
  modport master (
    output wrdata, wren, rden,
    input  full, almost_full, rddata, empty, count, overflow, underflow
  );

  modport slave (
    input  wrdata, wren, rden,
    output full, almost_full, rddata, empty, count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/lutram_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lutram_fifo                                                                |
// | 64-entry first-word-fall-through FIFO on per-bit 64x1 distributed RAMs     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

// 64x1 dual-port distributed RAM: port A is synchronous write plus async read,
// port B is async read only.
module lutram_64x1d (
  input  logic       clk,
  input  logic       we_i,
  input  logic [5:0] addr_a_i,
  input  logic       d_i,
  output logic       dout_a_o,
  input  logic [5:0] addr_b_i,
  output logic       dout_b_o
);
  logic [63:0] mem_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_a_i] <= d_i;
    end
  end

  assign dout_a_o = mem_q[addr_a_i];
  assign dout_b_o = mem_q[addr_b_i];
endmodule

module lutram_fifo #(
  parameter int WIDTH       = 8,
  parameter int AFULL_LEVEL = 48
) (
  input  logic         clk,
  input  logic         reset,
  lutram_fifo_if.slave fifo
);
  localparam logic [6:0] c_DEPTH = 7'd64;
  localparam logic [6:0] c_AFULL = 7'(AFULL_LEVEL);

  logic [5:0] wr_ptr_q, wr_ptr_d;
  logic [5:0] rd_ptr_q, rd_ptr_d;
  logic [6:0] count_q, count_d;
  logic       overflow_q, overflow_d;
  logic       underflow_q, underflow_d;

  logic       w_full;
  logic       w_empty;
  logic       w_push_ok;
  logic       w_pop_ok;
  logic       w_ram_we;
  logic [WIDTH-1:0] w_rd_word;
  logic [WIDTH-1:0] w_ram_a_unused;

  assign w_full    = (count_q == c_DEPTH);
  assign w_empty   = (count_q == 7'd0);
  // Each end is gated only by its own boundary, never by the other end's request.
  assign w_push_ok = fifo.wren & ~w_full;
  assign w_pop_ok  = fifo.rden & ~w_empty;
  assign w_ram_we  = w_push_ok & ~reset;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (fifo.wren & w_full);
    underflow_d = underflow_q | (fifo.rden & w_empty);

    if (w_push_ok) begin
      wr_ptr_d = wr_ptr_q + 6'd1;
    end
    if (w_pop_ok) begin
      rd_ptr_d = rd_ptr_q + 6'd1;
    end

    case ({w_push_ok, w_pop_ok})
      2'b10:   count_d = count_q + 7'd1;
      2'b01:   count_d = count_q - 7'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= 6'd0;
      rd_ptr_q    <= 6'd0;
      count_q     <= 7'd0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      lutram_64x1d u_ram (
        .clk      (clk),
        .we_i     (w_ram_we),
        .addr_a_i (wr_ptr_q),
        .d_i      (fifo.wrdata[gi]),
        .dout_a_o (w_ram_a_unused[gi]),
        .addr_b_i (rd_ptr_q),
        .dout_b_o (w_rd_word[gi])
      );
    end
  endgenerate

  assign fifo.rddata      = w_rd_word;
  assign fifo.full        = w_full;
  assign fifo.empty       = w_empty;
  assign fifo.almost_full = (count_q >= c_AFULL);
  assign fifo.count       = count_q;
  assign fifo.overflow    = overflow_q;
  assign fifo.underflow   = underflow_q;
endmodule
`default_nettype wire

// File: tb/tb_lutram_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lutram_fifo                                                             |
// | Randomized and directed bench for lutram_fifo against a queue model       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lutram_fifo;
  localparam int c_WIDTH = 8;
  localparam int c_AFULL = 48;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [7:0] mq[$];
  bit         m_ovf;
  bit         m_unf;

  lutram_fifo_if #(.WIDTH(c_WIDTH)) bus ();

  lutram_fifo #(.WIDTH(c_WIDTH), .AFULL_LEVEL(c_AFULL)) dut (
    .clk   (clk),
    .reset (reset),
    .fifo  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of traffic; the model applies the occupancy rules with a queue.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    int n;
    bus.wren   = w;
    bus.wrdata = d;
    bus.rden   = r;
    @(posedge clk);
    n = mq.size();
    if (w && n == 64) m_ovf = 1'b1;
    if (r && n == 0)  m_unf = 1'b1;
    if (r && n > 0)   void'(mq.pop_front());
    if (w && n < 64)  mq.push_back(d);
    #1;
    bus.wren = 1'b0;
    bus.rden = 1'b0;
  endtask

  task automatic do_reset(input logic w);
    bus.wren   = w;
    bus.wrdata = 8'hFF;
    bus.rden   = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    reset    = 1'b0;
    bus.wren = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++;
    if ({bus.count, bus.empty, bus.full, bus.almost_full, bus.overflow, bus.underflow}
        !== {7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got count=%0d e=%b f=%b af=%b ov=%b un=%b want 0 1 0 0 0 0",
               bus.count, bus.empty, bus.full, bus.almost_full, bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_fill_drain();
    do_reset(1'b0);
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      checks++;
      if (bus.count !== 7'(i + 1) || bus.almost_full !== ((i + 1) >= c_AFULL)) begin
        failures++;
        $display("FAIL fill_level push=%0d got count=%0d af=%b want count=%0d af=%b",
                 i + 1, bus.count, bus.almost_full, i + 1, ((i + 1) >= c_AFULL));
      end
    end
    checks++;
    if (bus.full !== 1'b1 || bus.empty !== 1'b0) begin
      failures++;
      $display("FAIL fill_full got full=%b empty=%b want 1 0", bus.full, bus.empty);
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (bus.rddata !== 8'(i)) begin
        failures++;
        $display("FAIL drain_data idx=%0d got %h want %h", i, bus.rddata, 8'(i));
      end
      cycle(1'b0, 8'h00, 1'b1);
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.count !== 7'd0) begin
      failures++;
      $display("FAIL drain_empty got empty=%b count=%0d want 1 0", bus.empty, bus.count);
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
    checks++;
    if (bus.count !== 7'd40) begin
      failures++;
      $display("FAIL wrap_count got %0d want 40", bus.count);
    end
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (bus.rddata !== 8'(8'h80 + i)) begin
        failures++;
        $display("FAIL wrap_data idx=%0d got %h want %h", i, bus.rddata, 8'(8'h80 + i));
      end
      cycle(1'b0, 8'h00, 1'b1);
    end
    checks++;
    if (bus.count !== 7'd0 || bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL wrap_end got count=%0d empty=%b want 0 1", bus.count, bus.empty);
    end
  endtask

  task automatic test_full_simul();
    do_reset(1'b0);
    for (int i = 0; i < 64; i++) cycle(1'b1, 8'(i) ^ 8'hC3, 1'b0);
    cycle(1'b1, 8'hEE, 1'b1);
    checks++;
    if (bus.count !== 7'd63 || bus.overflow !== 1'b1 || bus.underflow !== 1'b0) begin
      failures++;
      $display("FAIL full_simul got count=%0d ov=%b un=%b want 63 1 0",
               bus.count, bus.overflow, bus.underflow);
    end
    for (int i = 1; i < 64; i++) begin
      checks++;
      if (bus.rddata !== (8'(i) ^ 8'hC3)) begin
        failures++;
        $display("FAIL full_simul_drain idx=%0d got %h want %h", i, bus.rddata, 8'(i) ^ 8'hC3);
      end
      cycle(1'b0, 8'h00, 1'b1);
    end
    checks++;
    if (bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL full_simul_end got empty=%b want 1", bus.empty);
    end
  endtask

  task automatic test_empty_simul();
    do_reset(1'b0);
    cycle(1'b1, 8'h5A, 1'b1);
    checks++;
    if (bus.count !== 7'd1 || bus.underflow !== 1'b1 || bus.overflow !== 1'b0
        || bus.rddata !== 8'h5A) begin
      failures++;
      $display("FAIL empty_simul got count=%0d un=%b ov=%b data=%h want 1 1 0 5a",
               bus.count, bus.underflow, bus.overflow, bus.rddata);
    end
  endtask

  task automatic test_streaming();
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(i), 1'b0);
    for (int k = 0; k < 200; k++) begin
      checks++;
      if (bus.rddata !== 8'(k)) begin
        failures++;
        $display("FAIL stream_data k=%0d got %h want %h", k, bus.rddata, 8'(k));
      end
      cycle(1'b1, 8'(k + 10), 1'b1);
      checks++;
      if (bus.count !== 7'd10) begin
        failures++;
        $display("FAIL stream_count k=%0d got %0d want 10", k, bus.count);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset(1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (bus.count !== 7'd0 || bus.underflow !== 1'b1 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL pop_empty got count=%0d un=%b ov=%b want 0 1 0",
               bus.count, bus.underflow, bus.overflow);
    end
    cycle(1'b1, 8'h11, 1'b0);
    checks++;
    if (bus.rddata !== 8'h11 || bus.count !== 7'd1) begin
      failures++;
      $display("FAIL pop_empty_ptr got data=%h count=%0d want 11 1", bus.rddata, bus.count);
    end
    for (int i = 1; i < 64; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
    cycle(1'b1, 8'hDD, 1'b0);
    checks++;
    if (bus.count !== 7'd64 || bus.overflow !== 1'b1 || bus.rddata !== 8'h11) begin
      failures++;
      $display("FAIL push_full got count=%0d ov=%b data=%h want 64 1 11",
               bus.count, bus.overflow, bus.rddata);
    end
    for (int i = 0; i < 64; i++) cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (bus.overflow !== 1'b1 || bus.underflow !== 1'b1 || bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL sticky_hold got ov=%b un=%b empty=%b want 1 1 1",
               bus.overflow, bus.underflow, bus.empty);
    end
    do_reset(1'b0);
    checks++;
    if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      failures++;
      $display("FAIL sticky_clear got ov=%b un=%b want 0 0", bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'($urandom), 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h00, 1'b0);
    do_reset(1'b1);
    checks++;
    if ({bus.count, bus.empty, bus.overflow, bus.underflow} !== {7'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid got count=%0d empty=%b ov=%b un=%b want 0 1 0 0",
               bus.count, bus.empty, bus.overflow, bus.underflow);
    end
    cycle(1'b1, 8'h33, 1'b0);
    checks++;
    if (bus.rddata !== 8'h33 || bus.count !== 7'd1) begin
      failures++;
      $display("FAIL reset_mid_push got data=%h count=%0d want 33 1", bus.rddata, bus.count);
    end
  endtask

  task automatic test_random();
    logic w, r;
    int   n;
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      // Alternate filling and draining phases so both boundaries get exercised.
      w = ($urandom_range(0, 99) < (((i / 250) % 2 == 0) ? 85 : 15));
      r = ($urandom_range(0, 99) < (((i / 250) % 2 == 0) ? 15 : 85));
      if (mq.size() > 0) begin
        checks++;
        if (bus.rddata !== mq[0]) begin
          failures++;
          $display("FAIL rand_data cyc=%0d got %h want %h", i, bus.rddata, mq[0]);
        end
      end
      cycle(w, 8'($urandom), r);
      n = mq.size();
      checks++;
      if ({bus.count, bus.empty, bus.full, bus.almost_full, bus.overflow, bus.underflow}
          !== {7'(n), n == 0, n == 64, n >= c_AFULL, m_ovf, m_unf}) begin
        failures++;
        $display("FAIL rand_status cyc=%0d got count=%0d e=%b f=%b af=%b ov=%b un=%b want count=%0d e=%b f=%b af=%b ov=%b un=%b",
                 i, bus.count, bus.empty, bus.full, bus.almost_full, bus.overflow, bus.underflow,
                 n, n == 0, n == 64, n >= c_AFULL, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    m_ovf      = 1'b0;
    m_unf      = 1'b0;
    reset      = 1'b1;
    bus.wren   = 1'b0;
    bus.rden   = 1'b0;
    bus.wrdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_simul();
    test_empty_simul();
    test_streaming();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
